uart_rx: RTL

Memory-mapped 8N1 UART receiver; the receive-side counterpart to the existing uart_tx on the picorv32 bus.
- Samples the serial input (ftdi_txd at top level) and pushes each received byte into a small FIFO.
- Exposes a DATA and a STATUS register to the CPU through the standard valid/ready slave handshake.
- Decoded in the UART window (0x4000) alongside the transmitter; addr[2] selects the register.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sync_fifo.sv | 70 +++++++
 rtl/uart_rx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the memory-mapped UART blocks.
//             Receive FSM state encoding, register offsets (addr[2]) and
//             STATUS register bit positions.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   // Register select values (addr[2])
   localparam logic REG_DATA   = 1'b0;
   localparam logic REG_STATUS = 1'b1;

   // STATUS register bit positions
   localparam int ST_AVAIL     = 0;
   localparam int ST_OVR       = 1;
   localparam int ST_FERR      = 2;
   localparam int ST_COUNT_LSB = 8;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock first-word-fall-through FIFO. A push into a full
//             FIFO succeeds only when a pop happens in the same cycle; a pop
//             of an empty FIFO is ignored.
//  Ports    : clk, reset (sync, active-high)
//             push, din      write side
//             pop            read side (head is valid whenever empty=0)
//             full, empty    status levels
//             count          current occupancy, clog2(DEPTH)+1 bits
//             head           oldest entry
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      level;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == C_DEPTH);
   assign do_pop  = pop & ~empty;
   // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
   assign do_push = push & (~full | do_pop);
   assign count   = level;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage carries no reset; only pointers and level define validity.
   always_ff @(posedge clk) begin
      if (do_push && !reset) mem[wr_ptr] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Memory-mapped 8N1 UART receiver with receive FIFO.
//             DATA register (rs=0) pops the FIFO head; STATUS (rs=1) reports
//             {count[7:0], ferr, ovr, avail} and clears the sticky flags.
//  Ports    : clk, reset (sync, active-high)
//             rx        asynchronous serial input, idles high
//             cs        chip select, rs register select, we write strobe
//             dout      read data, valid while ready=1
//             ready     one-cycle bus acknowledge
//             rx_avail  FIFO not empty
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 2604,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   input  logic        cs,
   input  logic        rs,
   input  logic        we,
   output logic [31:0] dout,
   output logic        ready,
   output logic        rx_avail
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] C_HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] C_FULL_M1 = CW'(CLKS_PER_BIT - 1);

   // ------------------------------------------------------------------
   // Input synchronizer
   // ------------------------------------------------------------------
   logic rx_m;
   logic rx_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // ------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------
   rx_state_t   state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]  bit_idx, bit_nxt;
   logic [7:0]  shreg, shreg_nxt;
   logic        push_nxt;
   logic        ferr_set;
   logic        push_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         push_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_nxt;
         shreg   <= shreg_nxt;
         push_q  <= push_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;
      push_nxt  = 1'b0;
      ferr_set  = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            // Re-check the start bit half a bit in to reject glitches.
            if (cnt == C_HALF_M1) begin
               cnt_nxt = '0;
               if (!rx_s) begin
                  bit_nxt   = '0;
                  state_nxt = DATA;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt == C_FULL_M1) begin
               cnt_nxt   = '0;
               shreg_nxt = {rx_s, shreg[7:1]};
               bit_nxt   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            if (cnt == C_FULL_M1) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  push_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_set  = 1'b1;
                  state_nxt = BREAK;
               end
            end
         end
         BREAK: begin
            // Wait out a held-low line so it cannot spawn repeated frames.
            cnt_nxt = '0;
            if (rx_s) state_nxt = IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Receive FIFO
   // ------------------------------------------------------------------
   logic          fifo_full;
   logic          fifo_empty;
   logic [AW:0]   fifo_count;
   logic [7:0]    fifo_head;
   logic          fifo_pop;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_q),
      .din   (shreg),
      .pop   (fifo_pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .head  (fifo_head)
   );

   assign rx_avail = ~fifo_empty;

   // ------------------------------------------------------------------
   // Bus register logic
   // ------------------------------------------------------------------
   logic        access;
   logic        rd_data;
   logic        rd_status;
   logic        ovr_set;
   logic        ovr;
   logic        ferr;
   logic [31:0] status_word;

   assign access    = cs & ~ready;
   assign rd_data   = access & ~we & (rs == REG_DATA);
   assign rd_status = access & ~we & (rs == REG_STATUS);
   assign fifo_pop  = rd_data & ~fifo_empty;
   // The byte is lost only if no pop frees a slot in the same cycle.
   assign ovr_set   = push_q & fifo_full & ~fifo_pop;

   always_comb begin
      status_word                           = '0;
      status_word[ST_AVAIL]                 = ~fifo_empty;
      status_word[ST_OVR]                   = ovr;
      status_word[ST_FERR]                  = ferr;
      status_word[ST_COUNT_LSB +: 8]        = 8'(fifo_count);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ready <= 1'b0;
         dout  <= '0;
         ovr   <= 1'b0;
         ferr  <= 1'b0;
      end else begin
         ready <= access;
         if (access) begin
            if (rd_status)
               dout <= status_word;
            else if (rd_data && !fifo_empty)
               dout <= {24'h0, fifo_head};
            else
               dout <= '0;
         end
         // A flag raised in the same cycle as the clearing read survives.
         ovr  <= (ovr  & ~rd_status) | ovr_set;
         ferr <= (ferr & ~rd_status) | ferr_set;
      end
   end

endmodule
`default_nettype wire
